// File: rtl/vitals_pkg.sv
// Shared constants and state encoding for the vitals report frame transmitter.
package vitals_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [3:0] FRAME_LEN   = 4'd15;

  localparam logic [3:0] IDX_SOF  = 4'd0;
  localparam logic [3:0] IDX_SEQ  = 4'd1;
  localparam logic [3:0] IDX_CSUM = FRAME_LEN - 4'd1;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/report_byte_mux.sv
// Selects the frame byte for a given index from the frozen snapshot (checksum excluded).
module report_byte_mux
  import vitals_pkg::*;
#(
  parameter logic [7:0] SOF = SOF_DEFAULT
) (
  input  logic [3:0]  idx,
  input  logic [7:0]  seq,
  input  logic [15:0] steps,
  input  logic [31:0] distance,
  input  logic [7:0]  max_hr,
  input  logic [7:0]  avg_hr,
  input  logic [15:0] cal,
  input  logic [7:0]  time_el,
  input  logic [1:0]  hr_class,
  input  logic [1:0]  intensity,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = '0;
    case (idx)
      IDX_SOF: byte_o = SOF;
      IDX_SEQ: byte_o = seq;
      4'd2:    byte_o = steps[15:8];
      4'd3:    byte_o = steps[7:0];
      4'd4:    byte_o = distance[31:24];
      4'd5:    byte_o = distance[23:16];
      4'd6:    byte_o = distance[15:8];
      4'd7:    byte_o = distance[7:0];
      4'd8:    byte_o = max_hr;
      4'd9:    byte_o = avg_hr;
      4'd10:   byte_o = cal[15:8];
      4'd11:   byte_o = cal[7:0];
      4'd12:   byte_o = time_el;
      4'd13:   byte_o = {hr_class, intensity, 4'b0000};
      default: byte_o = '0;
    endcase
  end

endmodule

// File: rtl/vitals_report_tx.sv
// Snapshots step/classifier statistics on request and streams a 15-byte checksummed frame.
module vitals_report_tx
  import vitals_pkg::*;
#(
  parameter logic [7:0]  SOF    = SOF_DEFAULT,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap_req,
  input  logic [15:0]       total_steps,
  input  logic [31:0]       total_distance,
  input  logic [7:0]        max_heart_rate,
  input  logic [31:0]       average_heart_rate,
  input  logic [31:0]       total_calories,
  input  logic [7:0]        time_elapsed,
  input  logic [1:0]        hr_class,
  input  logic [1:0]        workout_intensity,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        seq_q, seq_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              frame_done_q, frame_done_d;

  logic [15:0] steps_q, steps_d;
  logic [31:0] dist_q, dist_d;
  logic [7:0]  max_hr_q, max_hr_d;
  logic [7:0]  avg_hr_q, avg_hr_d;
  logic [15:0] cal_q, cal_d;
  logic [7:0]  time_q, time_d;
  logic [1:0]  hr_class_q, hr_class_d;
  logic [1:0]  intensity_q, intensity_d;

  logic [7:0] mux_byte;
  logic       fire;

  report_byte_mux #(.SOF(SOF)) u_mux (
    .idx       (idx_q),
    .seq       (seq_q),
    .steps     (steps_q),
    .distance  (dist_q),
    .max_hr    (max_hr_q),
    .avg_hr    (avg_hr_q),
    .cal       (cal_q),
    .time_el   (time_q),
    .hr_class  (hr_class_q),
    .intensity (intensity_q),
    .byte_o    (mux_byte)
  );

  assign busy       = (state_q == SEND);
  assign tx_valid   = busy;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;
  assign fire       = tx_valid && tx_ready;

  always_comb begin
    tx_data = '0;
    if (busy) tx_data = (idx_q == IDX_CSUM) ? (~csum_q + 8'd1) : mux_byte;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    seq_d        = seq_q;
    drop_cnt_d   = drop_cnt_q;
    frame_done_d = 1'b0;
    steps_d      = steps_q;
    dist_d       = dist_q;
    max_hr_d     = max_hr_q;
    avg_hr_d     = avg_hr_q;
    cal_d        = cal_q;
    time_d       = time_q;
    hr_class_d   = hr_class_q;
    intensity_d  = intensity_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          steps_d     = total_steps;
          dist_d      = total_distance;
          max_hr_d    = max_heart_rate;
          avg_hr_d    = (|average_heart_rate[31:8]) ? 8'hFF : average_heart_rate[7:0];
          cal_d       = (|total_calories[31:16]) ? 16'hFFFF : total_calories[15:0];
          time_d      = time_elapsed;
          hr_class_d  = hr_class;
          intensity_d = workout_intensity;
          idx_d       = IDX_SOF;
          csum_d      = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Requests during a frame, including its final handshake cycle, are only counted.
        if (snap_req && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        if (fire) begin
          if ((idx_q != IDX_SOF) && (idx_q != IDX_CSUM)) csum_d = csum_q + mux_byte;
          if (idx_q == IDX_CSUM) begin
            state_d      = IDLE;
            idx_d        = IDX_SOF;
            seq_d        = seq_q + 8'd1;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      seq_q        <= '0;
      drop_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      steps_q      <= '0;
      dist_q       <= '0;
      max_hr_q     <= '0;
      avg_hr_q     <= '0;
      cal_q        <= '0;
      time_q       <= '0;
      hr_class_q   <= '0;
      intensity_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      seq_q        <= seq_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_done_q <= frame_done_d;
      steps_q      <= steps_d;
      dist_q       <= dist_d;
      max_hr_q     <= max_hr_d;
      avg_hr_q     <= avg_hr_d;
      cal_q        <= cal_d;
      time_q       <= time_d;
      hr_class_q   <= hr_class_d;
      intensity_q  <= intensity_d;
    end
  end

endmodule
